multadd_sched: RTL and testbench

- Two-requester scheduler that shares one external 8-bit two-term multiply-adder (S = A×B + C×D, fixed pipeline latency LAT) between requesters.
- Arbitrates operand requests round-robin and registers the granted operand set into the datapath.
- Tracks each in-flight operation's owner with a tag pipeline and returns every result tagged with its requester id.
- Provides a flush/drain sequence so software or the front panel can quiesce the unit before reconfiguring it.

---
 rtl/multadd_sched_pkg.sv | 14 +
 rtl/multadd_sched_rr_arb2.sv | 31 +++
 rtl/multadd_sched.sv | 149 ++++++++++++++
 tb/tb_multadd_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multadd_sched_pkg.sv
// Shared types and constants for the two-requester multiply-add scheduler.
package multadd_sched_pkg;
  localparam int W     = 8;
  localparam int RES_W = 2 * W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/multadd_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer only rotates when both requesters contend.
module rr_arb2
  import multadd_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  req_id_t ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end else begin
        // A lone requester wins regardless of the pointer and leaves it alone.
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/multadd_sched.sv
// Scheduler sharing one external A*B+C*D datapath between two requesters, with drain/flush FSM.
// Optional grant statistics are built when MULTADD_SCHED_STATS_EN is defined.
module multadd_sched
  import multadd_sched_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [4*W-1:0]   req0_ops_i,
  input  logic [4*W-1:0]   req1_ops_i,
  output logic             mac_issue_o,
  output logic [W-1:0]     mac_a_o,
  output logic [W-1:0]     mac_b_o,
  output logic [W-1:0]     mac_c_o,
  output logic [W-1:0]     mac_d_o,
  input  logic [RES_W-1:0] mac_result_i,
  output logic             res_valid_o,
  output logic             res_id_o,
  output logic [RES_W-1:0] res_data_o,
  output logic             flush_done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stat_cnt0_o,
  output logic [CNT_W-1:0] stat_cnt1_o
);
  state_e          state_q;
  logic            flush_done_q;
  logic [1:0]      gnt;
  logic            hs;
  req_id_t         win_id;
  logic [4*W-1:0]  win_ops;
  logic            issue_q;
  logic [4*W-1:0]  ops_q;
  tag_t [LAT:0]    tag_q;
  logic            res_valid_q;
  req_id_t         res_id_q;
  logic [RES_W-1:0] res_data_q;
  logic            busy;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i && (state_q == ST_RUN)),
    .req_i  (req_valid_i),
    .gnt_o  (gnt)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;
  assign win_id      = gnt[1];
  assign win_ops     = win_id ? req1_ops_i : req0_ops_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q <= 1'b0;
      ops_q   <= '0;
    end else begin
      issue_q <= hs;
      if (hs) ops_q <= win_ops;
    end
  end

  // tag_q[0] tracks the issue stage; tag_q[LAT] lines up with mac_result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tag_q <= '0;
    else         tag_q <= {tag_q[LAT-1:0], tag_t'{valid: hs, id: win_id}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tag_q[LAT].valid;
      if (tag_q[LAT].valid) begin
        res_id_q   <= tag_q[LAT].id;
        res_data_q <= mac_result_i;
      end
    end
  end

  always_comb begin
    busy = issue_q;
    for (int i = 0; i <= LAT; i++) busy = busy | tag_q[i].valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy) begin
            state_q      <= ST_DONE;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush_i) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULTADD_SCHED_STATS_EN
  logic done_entry;
  assign done_entry = (state_q == ST_DRAIN) && !busy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   cnt_q <= '0;
      else if (done_entry)           cnt_q <= '0;
      else if (gnt[gi] && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stat_cnt0_o = g_cnt[0].cnt_q;
  assign stat_cnt1_o = g_cnt[1].cnt_q;
`else
  assign stat_cnt0_o = '0;
  assign stat_cnt1_o = '0;
`endif

  assign mac_issue_o  = issue_q;
  assign {mac_a_o, mac_b_o, mac_c_o, mac_d_o} = ops_q;
  assign res_valid_o  = res_valid_q;
  assign res_id_o     = res_id_q;
  assign res_data_o   = res_data_q;
  assign flush_done_o = flush_done_q;
  assign busy_o       = busy;
endmodule

// File: tb/tb_multadd_sched.sv
// Self-checking bench for multadd_sched: queue-based scoreboard plus directed literal checks.
module tb_multadd_sched;
  localparam int LAT   = 2;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, flush;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req0_ops, req1_ops;
  logic        mac_issue;
  logic [7:0]  mac_a, mac_b, mac_c, mac_d;
  logic [16:0] mac_result;
  logic        res_valid, res_id;
  logic [16:0] res_data;
  logic        flush_done, busy;
  logic [CNT_W-1:0] stat_cnt0, stat_cnt1;

  multadd_sched #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_ops_i(req0_ops), .req1_ops_i(req1_ops),
    .mac_issue_o(mac_issue), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_c_o(mac_c), .mac_d_o(mac_d),
    .mac_result_i(mac_result), .res_valid_o(res_valid), .res_id_o(res_id), .res_data_o(res_data),
    .flush_done_o(flush_done), .busy_o(busy), .stat_cnt0_o(stat_cnt0), .stat_cnt1_o(stat_cnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] madd(input logic [31:0] o);
    return 17'(o[31:24]) * 17'(o[23:16]) + 17'(o[15:8]) * 17'(o[7:0]);
  endfunction

  // External datapath: result of an issue appears LAT cycles later; filler otherwise.
  logic [16:0] dp_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) dp_pipe[i] <= dp_pipe[i-1];
    dp_pipe[0] <= mac_issue ? madd({mac_a, mac_b, mac_c, mac_d}) : (17'h15A5A ^ 17'(cyc));
  end
  assign mac_result = dp_pipe[LAT-1];

  // Behavioural model state
  typedef struct {
    int          id;
    logic [31:0] ops;
    int          hc;
  } op_t;
  typedef enum int {M_RUN, M_DRAIN, M_DONE} mstate_t;

  op_t         sb[$];
  mstate_t     m_state = M_RUN;
  logic        m_ptr = 1'b0;
  logic        m_issue = 1'b0;
  logic [31:0] m_ops = '0;
  int          g_id[$], g_cyc[$], r_id[$], r_cyc[$];
  logic [16:0] r_data[$];
  int          busy_fall = -1, done_rise = -1;
  logic        prev_busy = 1'b0, prev_fd = 1'b0;

  always @(negedge clk) begin
    logic [1:0] eg;
    logic       mb;
    op_t        e;
    if (!rst_n) begin
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_mac_issue", 32'(mac_issue), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      sb.delete();
      m_state = M_RUN; m_ptr = 1'b0; m_issue = 1'b0; m_ops = '0;
      prev_busy = 1'b0; prev_fd = 1'b0;
    end else begin
      eg = 2'b00;
      if (en && m_state == M_RUN)
        eg = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("mac_issue", 32'(mac_issue), 32'(m_issue));
      if (m_issue) chk("mac_ops", {mac_a, mac_b, mac_c, mac_d}, m_ops);
      mb = 1'b0;
      foreach (sb[i]) if (cyc >= sb[i].hc + 1 && cyc <= sb[i].hc + 1 + LAT) mb = 1'b1;
      chk("busy", 32'(busy), 32'(mb));
      if (sb.size() > 0 && sb[0].hc + LAT + 2 == cyc) begin
        e = sb.pop_front();
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(madd(e.ops)));
        r_id.push_back(int'(res_id)); r_cyc.push_back(cyc); r_data.push_back(res_data);
        $display("result: cycle %0d id %0d data %05h", cyc, res_id, res_data);
      end else begin
        chk("res_valid_idle", 32'(res_valid), 32'd0);
      end
      chk("flush_done", 32'(flush_done), 32'(m_state == M_DONE));
      if (prev_busy && !busy) busy_fall = cyc;
      if (!prev_fd && flush_done) done_rise = cyc;
      prev_busy = busy; prev_fd = flush_done;
      // advance the model to the next cycle
      m_issue = |eg;
      if (|eg) begin
        e.id = int'(eg[1]); e.ops = eg[1] ? req1_ops : req0_ops; e.hc = cyc;
        sb.push_back(e); m_ops = e.ops;
        g_id.push_back(e.id); g_cyc.push_back(cyc);
      end
      if (en && m_state == M_RUN && req_valid == 2'b11) m_ptr = ~m_ptr;
      case (m_state)
        M_RUN:   if (flush) m_state = M_DRAIN;
        M_DRAIN: if (!mb) m_state = M_DONE;
        default: if (!flush) m_state = M_RUN;
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!flush_done && n < 30) begin @(negedge clk); n++; end
    chk("flush_done_reached", 32'(flush_done), 32'd1);
    step();
  endtask

  initial begin
    int hs0, fcyc;
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0, fcyc;
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; req_valid = 2'b00;
    req0_ops = '0; req1_ops = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    // Basic: single handshake from requester 0
    r_id.delete(); r_cyc.delete(); r_data.delete();
    req_valid = 2'b01; req0_ops = 32'h12345678; hs0 = cyc;
    step();
    req_valid = 2'b00;
    chk("basic_issue", 32'(mac_issue), 32'd1);
    repeat (6) step();
    chk("basic_count", 32'(r_id.size()), 32'd1);
    chk("basic_data", 32'(r_data[0]), 32'h02BF8);
    chk("basic_id", 32'(r_id[0]), 32'd0);
    chk("basic_latency", 32'(r_cyc[0] - hs0), 32'd4);
    chk("stats_tied_or_counting", 32'(stat_cnt1), 32'd0);

    // Contention: both valid for 6 cycles
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req0_ops = $urandom; req1_ops = $urandom;
      step();
    end
    req_valid = 2'b00;
    repeat (6) step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_grant%0d", i), 32'(g_id[i]), 32'(i % 2));
      chk($sformatf("cont_result%0d", i), 32'(r_id[i]), 32'(i % 2));
      chk($sformatf("cont_lat%0d", i), 32'(r_cyc[i] - g_cyc[i]), 32'd4);
    end

    // Maximum value from requester 1
    r_id.delete(); r_cyc.delete(); r_data.delete();
    req_valid = 2'b10; req1_ops = 32'hFFFFFFFF;
    step();
    req_valid = 2'b00;
    repeat (6) step();
    chk("max_data", 32'(r_data[0]), 32'h1FC02);
    chk("max_msb", 32'(r_data[0][16]), 32'd1);
    chk("max_id", 32'(r_id[0]), 32'd1);

    // en low blocks grants; then re-enable
    g_id.delete();
    en = 1'b0; req_valid = 2'b11;
    repeat (3) step();
    chk("en_low_no_grant", 32'(g_id.size()), 32'd0);
    en = 1'b1;
    step();
    req_valid = 2'b00;
    repeat (5) step();

    // Flush together with a grant
    r_id.delete(); r_cyc.delete(); r_data.delete();
    req_valid = 2'b01; req0_ops = 32'h0A0B0C0D; flush = 1'b1; fcyc = cyc;
    step();
    req_valid = 2'b11;
    wait_done();
    chk("flush_done_after_busy", 32'(done_rise - busy_fall), 32'd1);
    chk("flush_result_count", 32'(r_id.size()), 32'd1);
    chk("flush_result_lat", 32'(r_cyc[0] - fcyc), 32'd4);
    repeat (2) step();
    g_id.delete();
    flush = 1'b0;
    repeat (2) step();
    chk("flush_resume_grant", 32'(g_id.size()), 32'd1);
    req_valid = 2'b00;
    repeat (6) step();

    // Reset with 3 operations in flight; pointer left at requester 1
    req_valid = 2'b11;
    repeat (3) step();
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_res_valid", 32'(res_valid), 32'd0);
    chk("rst_now_issue", 32'(mac_issue), 32'd0);
    chk("rst_now_busy", 32'(busy), 32'd0);
    chk("rst_now_mac_a", 32'(mac_a), 32'd0);
    chk("rst_now_res_data", 32'(res_data), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    g_id.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
    repeat (10) step();
    chk("rst_no_results", 32'(r_id.size()), 32'd0);
    req_valid = 2'b11;
    repeat (2) step();
    req_valid = 2'b00;
    chk("rst_first_grant", 32'(g_id[0]), 32'd0);
    repeat (6) step();

`ifdef MULTADD_SCHED_STATS_EN
    req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin req0_ops = $urandom; step(); end
    req_valid = 2'b00;
    chk("stat_cnt0_sat", 32'(stat_cnt0), 32'hF);
    flush = 1'b1;
    wait_done();
    chk("stat_cnt0_clear", 32'(stat_cnt0), 32'd0);
    flush = 1'b0;
    repeat (3) step();
`else
    chk("stat_cnt0_tied", 32'(stat_cnt0), 32'd0);
    chk("stat_cnt1_tied", 32'(stat_cnt1), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
